// File: rtl/freqdiv_sync_ctrl.sv
// Alignment controller for the integer clock dividers: holds their `sync` low for HOLD_CYC
// cycles, releases them together and pulses `ack` after SETTLE_CYC cycles. Macro TRIG_SYNC_EN adds a synchronized `trig` input.
module freqdiv_sync_ctrl #(
  parameter int HOLD_CYC   = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req,
`ifdef TRIG_SYNC_EN
  input  logic       trig,
`endif
  output logic       sync,
  output logic       busy,
  output logic       ack,
  output logic [1:0] fsm_state
);

  localparam int MAX_CYC = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pending, pending_nxt;
  logic             start;

  // Request/ack handshake: `start` is sampled on every rising clk_in edge, level or pulse.
  // Requests landing in HOLD merge into the running alignment, requests in SETTLE queue one
  // re-alignment, and `ack` pulses once per completed alignment.
`ifdef TRIG_SYNC_EN
  logic trig_s1, trig_s2, trig_s3;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end

  assign start = req | (trig_s2 & ~trig_s3);
`else
  assign start = req;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    pending_nxt = pending;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = HOLD;
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = (SETTLE_CYC == 0) ? DONE : SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (start) pending_nxt = 1'b1;
        if (cnt == SETTLE_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        cnt_nxt     = '0;
        pending_nxt = 1'b0;
        state_nxt   = (pending || start) ? HOLD : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change in the same edge as the state.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state   <= HOLD;
      cnt     <= '0;
      pending <= 1'b0;
      sync    <= 1'b0;
      busy    <= 1'b1;
      ack     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      sync    <= (state_nxt != HOLD);
      busy    <= (state_nxt != IDLE);
      ack     <= (state_nxt == DONE);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_freqdiv_sync_ctrl.sv
// Directed bench for freqdiv_sync_ctrl: default instance (4/8) plus a HOLD_CYC=1, SETTLE_CYC=0 instance.
module tb_freqdiv_sync_ctrl;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       req;
  logic       req_z;
  logic       sync, busy, ack;
  logic       sync_z, busy_z, ack_z;
  logic [1:0] fsm_state, fsm_state_z;
`ifdef TRIG_SYNC_EN
  logic       trig;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_in = ~clk_in;

  freqdiv_sync_ctrl #(.HOLD_CYC(4), .SETTLE_CYC(8)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .req       (req),
`ifdef TRIG_SYNC_EN
    .trig      (trig),
`endif
    .sync      (sync),
    .busy      (busy),
    .ack       (ack),
    .fsm_state (fsm_state)
  );

  freqdiv_sync_ctrl #(.HOLD_CYC(1), .SETTLE_CYC(0)) dut_z (
    .clk_in    (clk_in),
    .rst       (rst),
    .req       (req_z),
`ifdef TRIG_SYNC_EN
    .trig      (1'b0),
`endif
    .sync      (sync_z),
    .busy      (busy_z),
    .ack       (ack_z),
    .fsm_state (fsm_state_z)
  );

  task automatic test_reset();
    logic e_sync, e_busy, e_ack;
    repeat (2) @(negedge clk_in);
    total_cnt++;
    if (sync !== 1'b0 || busy !== 1'b1 || ack !== 1'b0 || fsm_state !== 2'd1) begin
      $display("FAIL reset_vals: sync=%b busy=%b ack=%b state=%0d, need 0 1 0 1", sync, busy, ack, fsm_state);
    end else pass_cnt++;
    total_cnt++;
    if (sync_z !== 1'b0 || busy_z !== 1'b1) begin
      $display("FAIL reset_vals_z: sync=%b busy=%b, need 0 1", sync_z, busy_z);
    end else pass_cnt++;
    @(negedge clk_in);
    rst = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      if (i > 1) @(negedge clk_in);
      e_sync = (i >= 5);
      e_busy = (i <= 13);
      e_ack  = (i == 13);
      total_cnt++;
      if (sync !== e_sync || busy !== e_busy || ack !== e_ack) begin
        $display("FAIL power_on cyc %0d: sync=%b busy=%b ack=%b, need %b %b %b",
                 i, sync, busy, ack, e_sync, e_busy, e_ack);
      end else pass_cnt++;
    end
  endtask

  task automatic test_req_pulse();
    logic e_sync, e_busy, e_ack;
    int acks = 0;
    req = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk_in);
      req = 1'b0;
      e_sync = (j > 4);
      e_busy = (j <= 13);
      e_ack  = (j == 13);
      if (ack === 1'b1) acks++;
      total_cnt++;
      if (sync !== e_sync || busy !== e_busy || ack !== e_ack) begin
        $display("FAIL req_pulse cyc %0d: sync=%b busy=%b ack=%b, need %b %b %b",
                 j, sync, busy, ack, e_sync, e_busy, e_ack);
      end else pass_cnt++;
    end
    total_cnt++;
    if (acks != 1) $display("FAIL req_pulse_acks: got %0d, need 1", acks);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic e_sync, e_busy, e_ack;
    req = 1'b1;
    for (int j = 1; j <= 28; j++) begin
      @(negedge clk_in);
      req = (j == 2 || j == 3 || j == 6 || j == 9);
      e_sync = !((j >= 1 && j <= 4) || (j >= 14 && j <= 17));
      e_busy = (j <= 26);
      e_ack  = (j == 13 || j == 26);
      total_cnt++;
      if (sync !== e_sync || busy !== e_busy || ack !== e_ack) begin
        $display("FAIL back_to_back cyc %0d: sync=%b busy=%b ack=%b, need %b %b %b",
                 j, sync, busy, ack, e_sync, e_busy, e_ack);
      end else pass_cnt++;
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    logic e_sync, e_busy, e_ack;
    int acks = 0;
    req = 1'b1;
    @(negedge clk_in);
    req = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (sync !== 1'b0 || ack !== 1'b0 || busy !== 1'b1 || fsm_state !== 2'd1) begin
      $display("FAIL mid_reset: sync=%b ack=%b busy=%b state=%0d, need 0 0 1 1", sync, ack, busy, fsm_state);
    end else pass_cnt++;
    repeat (2) @(negedge clk_in);
    rst = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      if (i > 1) @(negedge clk_in);
      e_sync = (i >= 5);
      e_busy = (i <= 13);
      e_ack  = (i == 13);
      if (ack === 1'b1) acks++;
      total_cnt++;
      if (sync !== e_sync || busy !== e_busy || ack !== e_ack) begin
        $display("FAIL mid_reset_seq cyc %0d: sync=%b busy=%b ack=%b, need %b %b %b",
                 i, sync, busy, ack, e_sync, e_busy, e_ack);
      end else pass_cnt++;
    end
    total_cnt++;
    if (acks != 1) $display("FAIL mid_reset_acks: got %0d, need 1", acks);
    else pass_cnt++;
  endtask

  task automatic test_zero_settle();
    logic e_sync, e_busy, e_ack;
    req_z = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk_in);
      req_z = 1'b0;
      e_sync = (j != 1);
      e_busy = (j <= 2);
      e_ack  = (j == 2);
      total_cnt++;
      if (sync_z !== e_sync || busy_z !== e_busy || ack_z !== e_ack) begin
        $display("FAIL zero_settle cyc %0d: sync=%b busy=%b ack=%b, need %b %b %b",
                 j, sync_z, busy_z, ack_z, e_sync, e_busy, e_ack);
      end else pass_cnt++;
    end
  endtask

`ifdef TRIG_SYNC_EN
  task automatic test_trig();
    logic e_sync, e_ack;
    int acks = 0;
    @(negedge clk_in);
    #3 trig = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk_in);
      if (j == 1) #3 trig = 1'b0;
      e_sync = !(j >= 3 && j <= 6);
      e_ack  = (j == 15);
      total_cnt++;
      if (sync !== e_sync || ack !== e_ack) begin
        $display("FAIL trig_pulse cyc %0d: sync=%b ack=%b, need %b %b", j, sync, ack, e_sync, e_ack);
      end else pass_cnt++;
    end
    @(negedge clk_in);
    trig = 1'b1;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk_in);
      if (j == 50) trig = 1'b0;
      if (ack === 1'b1) acks++;
    end
    total_cnt++;
    if (acks != 1 || busy !== 1'b0) $display("FAIL trig_held: acks=%0d busy=%b, need 1 0", acks, busy);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst   = 1'b0;
    req   = 1'b0;
    req_z = 1'b0;
`ifdef TRIG_SYNC_EN
    trig  = 1'b0;
`endif
    test_reset();
    test_req_pulse();
    test_back_to_back();
    test_reset_mid_hold();
    test_zero_settle();
`ifdef TRIG_SYNC_EN
    test_trig();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
